// File: rtl/token_multiplier.sv
// token_multiplier: serial token expander.
// Every '1' sampled on `a` becomes FACTOR '1' tokens on `b`. At most one token
// leaves per cycle; tokens not yet sent wait in a saturating pending counter.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous reset, active-low (0 = reset)
//   a        - incoming token (1 = one token this cycle)
//   b        - outgoing token, combinational, zero latency from `a`
//   pending  - registered pending-token count
//   overflow - sticky flag, set when a token was discarded by saturation
//   dropped  - (TOKEN_MULT_STATS_EN only) saturating count of discarded tokens
//
// Optional feature macro: TOKEN_MULT_STATS_EN
module token_multiplier #(
  parameter int unsigned FACTOR      = 2,
  parameter int unsigned MAX_PENDING = 255,
  localparam int unsigned CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             b,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
`ifdef TOKEN_MULT_STATS_EN
  ,
  output logic [15:0]      dropped
`endif
);

  // Wide enough that P + FACTOR never wraps before the saturation compare.
  localparam int unsigned NW = CNT_W + 9;

  logic [CNT_W-1:0] pending_d, pending_q;
  logic             overflow_d, overflow_q;
  logic [NW-1:0]    next_sum;
  logic             clamp;

  // Emit rule and next-state arithmetic.
  always_comb begin
    b          = rst & (a | (pending_q != '0));
    next_sum   = NW'(pending_q) + (a ? NW'(FACTOR) : '0) - (b ? NW'(1) : '0);
    clamp      = (next_sum > NW'(MAX_PENDING));
    pending_d  = clamp ? CNT_W'(MAX_PENDING) : CNT_W'(next_sum);
    overflow_d = overflow_q | clamp;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;

`ifdef TOKEN_MULT_STATS_EN
  logic [15:0]   dropped_d, dropped_q;
  logic [NW-1:0] excess;
  logic [16:0]   drop_sum;

  // Accumulate tokens lost on each clamping edge; holds at all-ones.
  always_comb begin
    excess    = next_sum - NW'(MAX_PENDING);
    drop_sum  = 17'(dropped_q) + 17'(excess);
    dropped_d = dropped_q;
    if (clamp) begin
      dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= dropped_d;
    end
  end

  assign dropped = dropped_q;
`endif

endmodule

// File: tb/tb_token_multiplier.sv
// Directed bench for token_multiplier. Four instances cover the configurations
// exercised: FACTOR=2/MAX=255, FACTOR=2/MAX=3, FACTOR=1, FACTOR=3.
module tb_token_multiplier;

  logic clk;
  logic rst;
  logic a_v [4];

  logic       b_v [4];
  logic [31:0] pend_v [4];
  logic       ovf_v [4];

  logic [7:0] p0, p2, p3;
  logic [1:0] p1;
  logic       b0, b1, b2, b3;
  logic       o0, o1, o2, o3;
`ifdef TOKEN_MULT_STATS_EN
  logic [15:0] d0, d1, d2, d3;
`endif

  int tests_run;
  int tests_failed;
  int b_ones;

  // inst 0: FACTOR=2, MAX_PENDING=255
  token_multiplier #(.FACTOR(2), .MAX_PENDING(255)) u_f2 (
    .clk(clk), .rst(rst), .a(a_v[0]), .b(b0), .pending(p0), .overflow(o0)
`ifdef TOKEN_MULT_STATS_EN
    , .dropped(d0)
`endif
  );

  // inst 1: FACTOR=2, MAX_PENDING=3
  token_multiplier #(.FACTOR(2), .MAX_PENDING(3)) u_f2_sat (
    .clk(clk), .rst(rst), .a(a_v[1]), .b(b1), .pending(p1), .overflow(o1)
`ifdef TOKEN_MULT_STATS_EN
    , .dropped(d1)
`endif
  );

  // inst 2: FACTOR=1
  token_multiplier #(.FACTOR(1), .MAX_PENDING(255)) u_f1 (
    .clk(clk), .rst(rst), .a(a_v[2]), .b(b2), .pending(p2), .overflow(o2)
`ifdef TOKEN_MULT_STATS_EN
    , .dropped(d2)
`endif
  );

  // inst 3: FACTOR=3
  token_multiplier #(.FACTOR(3), .MAX_PENDING(255)) u_f3 (
    .clk(clk), .rst(rst), .a(a_v[3]), .b(b3), .pending(p3), .overflow(o3)
`ifdef TOKEN_MULT_STATS_EN
    , .dropped(d3)
`endif
  );

  assign b_v[0] = b0;
  assign b_v[1] = b1;
  assign b_v[2] = b2;
  assign b_v[3] = b3;
  assign pend_v[0] = 32'(p0);
  assign pend_v[1] = 32'(p1);
  assign pend_v[2] = 32'(p2);
  assign pend_v[3] = 32'(p3);
  assign ovf_v[0] = o0;
  assign ovf_v[1] = o1;
  assign ovf_v[2] = o2;
  assign ovf_v[3] = o3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle on instance i: drive rst/a, check combinational b before the
  // edge, then pending and overflow after it.
  task automatic step(input int i, input logic r, input logic ai, input logic exp_b,
                      input int exp_p, input logic exp_o, input string tag);
    @(negedge clk);
    rst    = r;
    a_v[i] = ai;
    #1;
    check({tag, ".b"}, 32'(b_v[i]), 32'(exp_b));
    if (b_v[i] === 1'b1) b_ones++;
    @(posedge clk);
    #1;
    check({tag, ".pending"}, pend_v[i], 32'(exp_p));
    check({tag, ".overflow"}, 32'(ovf_v[i]), 32'(exp_o));
  endtask

  initial begin
    logic ai;
    tests_run    = 0;
    tests_failed = 0;
    b_ones       = 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) a_v[i] = 1'b0;

    // Reset state on every instance.
    step(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "rst0");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_b%0d", i), 32'(b_v[i]), 32'd0);
      check($sformatf("rst_p%0d", i), pend_v[i], 32'd0);
      check($sformatf("rst_o%0d", i), 32'(ovf_v[i]), 32'd0);
    end
    a_v[0] = 1'b0;

    // Single token, FACTOR=2.
    step(0, 1'b1, 1'b1, 1'b1, 1, 1'b0, "t1_c0");
    step(0, 1'b1, 1'b0, 1'b1, 0, 1'b0, "t1_c1");
    step(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "t1_c2");

    // Three-token burst, FACTOR=2: six consecutive output tokens.
    b_ones = 0;
    step(0, 1'b1, 1'b1, 1'b1, 1, 1'b0, "t2_c0");
    step(0, 1'b1, 1'b1, 1'b1, 2, 1'b0, "t2_c1");
    step(0, 1'b1, 1'b1, 1'b1, 3, 1'b0, "t2_c2");
    step(0, 1'b1, 1'b0, 1'b1, 2, 1'b0, "t2_c3");
    step(0, 1'b1, 1'b0, 1'b1, 1, 1'b0, "t2_c4");
    step(0, 1'b1, 1'b0, 1'b1, 0, 1'b0, "t2_c5");
    step(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "t2_c6");
    check("t2_b_ones", 32'(b_ones), 32'd6);

    // Reset mid-burst: tokens lost, b held low, nothing emitted after release.
    step(0, 1'b1, 1'b1, 1'b1, 1, 1'b0, "t4_c0");
    step(0, 1'b1, 1'b1, 1'b1, 2, 1'b0, "t4_c1");
    step(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "t4_r0");
    step(0, 1'b0, 1'b1, 1'b0, 0, 1'b0, "t4_r1");
    step(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "t4_c2");
    step(0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "t4_c3");

    // Saturation, FACTOR=2, MAX_PENDING=3: clamps on edges 4..6.
    step(1, 1'b1, 1'b1, 1'b1, 1, 1'b0, "t3_c0");
    step(1, 1'b1, 1'b1, 1'b1, 2, 1'b0, "t3_c1");
    step(1, 1'b1, 1'b1, 1'b1, 3, 1'b0, "t3_c2");
    step(1, 1'b1, 1'b1, 1'b1, 3, 1'b1, "t3_c3");
    step(1, 1'b1, 1'b1, 1'b1, 3, 1'b1, "t3_c4");
    step(1, 1'b1, 1'b1, 1'b1, 3, 1'b1, "t3_c5");
    // Drain from MAX_PENDING with a=0: decrements, overflow stays sticky.
    step(1, 1'b1, 1'b0, 1'b1, 2, 1'b1, "t3_d0");
    step(1, 1'b1, 1'b0, 1'b1, 1, 1'b1, "t3_d1");
    step(1, 1'b1, 1'b0, 1'b1, 0, 1'b1, "t3_d2");
    step(1, 1'b1, 1'b0, 1'b0, 0, 1'b1, "t3_d3");
`ifdef TOKEN_MULT_STATS_EN
    check("t3_dropped", 32'(d1), 32'd3);
    check("t2_dropped", 32'(d0), 32'd0);
`endif

    // FACTOR=1: pass-through.
    for (int k = 0; k < 40; k++) begin
      ai = 1'($urandom_range(0, 1));
      step(2, 1'b1, ai, ai, 0, 1'b0, $sformatf("t5_c%0d", k));
    end

    // FACTOR=3, a = 1,0,1 then zeros.
    b_ones = 0;
    step(3, 1'b1, 1'b1, 1'b1, 2, 1'b0, "t6_c0");
    step(3, 1'b1, 1'b0, 1'b1, 1, 1'b0, "t6_c1");
    step(3, 1'b1, 1'b1, 1'b1, 3, 1'b0, "t6_c2");
    step(3, 1'b1, 1'b0, 1'b1, 2, 1'b0, "t6_c3");
    step(3, 1'b1, 1'b0, 1'b1, 1, 1'b0, "t6_c4");
    step(3, 1'b1, 1'b0, 1'b1, 0, 1'b0, "t6_c5");
    step(3, 1'b1, 1'b0, 1'b0, 0, 1'b0, "t6_c6");
    check("t6_b_ones", 32'(b_ones), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
